// File: rtl/gpr_file_if.sv
// Register-file bus between the pipeline (master: ID read, WB write, debug read) and gpr_file (slave).
interface gpr_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] id_raddr1;
    logic [ADDR_WIDTH-1:0] id_raddr2;
    logic [DATA_WIDTH-1:0] id_rdata1;
    logic [DATA_WIDTH-1:0] id_rdata2;
    logic                  wb_we;
    logic [ADDR_WIDTH-1:0] wb_waddr;
    logic [DATA_WIDTH-1:0] wb_wdata;
    logic                  wb_hi_we;
    logic [DATA_WIDTH-1:0] wb_hi_wdata;
    logic                  wb_lo_we;
    logic [DATA_WIDTH-1:0] wb_lo_wdata;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [ADDR_WIDTH-1:0] dbg_raddr;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    // No handshake: every write is accepted in its own cycle, reads are combinational.
    modport master (
        output id_raddr1, id_raddr2, wb_we, wb_waddr, wb_wdata,
               wb_hi_we, wb_hi_wdata, wb_lo_we, wb_lo_wdata, dbg_raddr,
        input  id_rdata1, id_rdata2, hi, lo, dbg_rdata
    );

    modport slave (
        input  id_raddr1, id_raddr2, wb_we, wb_waddr, wb_wdata,
               wb_hi_we, wb_hi_wdata, wb_lo_we, wb_lo_wdata, dbg_raddr,
        output id_rdata1, id_rdata2, hi, lo, dbg_rdata
    );
endinterface

// File: rtl/gpr_file.sv
// Architectural GPR file with HI/LO; register 0 reads as zero and has no storage.
// Define GPR_WRITE_THROUGH_EN to forward same-cycle WB writes onto the ID and HI/LO reads.
module gpr_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    gpr_file_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [1:NREG-1];
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] dbg;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            // waddr/wdata are only looked at when we is high, so junk on them is harmless.
            if (bus.wb_we && (bus.wb_waddr != '0)) regs[bus.wb_waddr] <= bus.wb_wdata;
            if (bus.wb_hi_we) hi_q <= bus.wb_hi_wdata;
            if (bus.wb_lo_we) lo_q <= bus.wb_lo_wdata;
        end
    end

    always_comb begin
        rd1    = '0;
        rd2    = '0;
        dbg    = '0;
        hi_out = hi_q;
        lo_out = lo_q;
        if (bus.id_raddr1 != '0) rd1 = regs[bus.id_raddr1];
        if (bus.id_raddr2 != '0) rd2 = regs[bus.id_raddr2];
        if (bus.dbg_raddr != '0) dbg = regs[bus.dbg_raddr];
`ifdef GPR_WRITE_THROUGH_EN
        // Closes the WB->ID hazard; the debug port deliberately keeps showing stored state.
        if (bus.wb_we && (bus.wb_waddr != '0) && (bus.wb_waddr == bus.id_raddr1)) rd1 = bus.wb_wdata;
        if (bus.wb_we && (bus.wb_waddr != '0) && (bus.wb_waddr == bus.id_raddr2)) rd2 = bus.wb_wdata;
        if (bus.wb_hi_we) hi_out = bus.wb_hi_wdata;
        if (bus.wb_lo_we) lo_out = bus.wb_lo_wdata;
`else
        // Stored values only; ID must stall a cycle on a WB->ID index match.
`endif
    end

    assign bus.id_rdata1 = rd1;
    assign bus.id_rdata2 = rd2;
    assign bus.dbg_rdata = dbg;
    assign bus.hi        = hi_out;
    assign bus.lo        = lo_out;
endmodule

// File: tb/tb_gpr_file.sv
// Randomized scoreboard bench for gpr_file: driver pushes expected reads, monitor pops and compares.
module tb_gpr_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int W  = 5 * DW;
`ifdef GPR_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   obs_idx  = 0;

    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] model_regs [0:(2**AW)-1];
    logic [DW-1:0] model_hi;
    logic [DW-1:0] model_lo;

    gpr_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    gpr_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 1'b1;
        bus.id_raddr1 = '0; bus.id_raddr2 = '0; bus.dbg_raddr = '0;
        bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
        bus.wb_hi_we = 1'b0; bus.wb_hi_wdata = '0;
        bus.wb_lo_we = 1'b0; bus.wb_lo_wdata = '0;
    end

    task automatic model_clear();
        for (int i = 0; i < 2**AW; i++) model_regs[i] = '0;
        model_hi = '0;
        model_lo = '0;
    endtask

    function automatic logic [DW-1:0] exp_id(input logic [AW-1:0] ra, input logic we,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (ra == 0) return '0;
        if (WT && we && wa != 0 && wa == ra) return wd;
        return model_regs[ra];
    endfunction

    // mode 0: normal cycle, 1: reset held low across the edge, 2: reset pulsed low before the edge
    task automatic step(input int mode,
                        input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input logic [AW-1:0] dba,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic hwe, input logic [DW-1:0] hd,
                        input logic lwe, input logic [DW-1:0] ld);
        logic [DW-1:0] e1, e2, eh, el, ed;
        @(negedge clk);
        bus.id_raddr1 = ra1; bus.id_raddr2 = ra2; bus.dbg_raddr = dba;
        bus.wb_we = we; bus.wb_waddr = wa; bus.wb_wdata = wd;
        bus.wb_hi_we = hwe; bus.wb_hi_wdata = hd;
        bus.wb_lo_we = lwe; bus.wb_lo_wdata = ld;
        if (mode != 0) begin
            rst_n = 1'b0;
            model_clear();
        end else begin
            rst_n = 1'b1;
        end
        e1 = exp_id(ra1, we, wa, wd);
        e2 = exp_id(ra2, we, wa, wd);
        eh = (WT && hwe) ? hd : model_hi;
        el = (WT && lwe) ? ld : model_lo;
        ed = (dba == 0) ? '0 : model_regs[dba];
        exp_q.push_back({e1, e2, eh, el, ed});
        if (mode == 2) begin
            #4 rst_n = 1'b1;
        end
        @(posedge clk);
        if (rst_n) begin
            if (we && wa != 0) model_regs[wa] = wd;
            if (hwe) model_hi = hd;
            if (lwe) model_lo = ld;
        end
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d actual=%h expected=%h", name, obs_idx, act, exp);
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("id_rdata1", bus.id_rdata1, e[5*DW-1:4*DW]);
                chk("id_rdata2", bus.id_rdata2, e[4*DW-1:3*DW]);
                chk("hi",        bus.hi,        e[3*DW-1:2*DW]);
                chk("lo",        bus.lo,        e[2*DW-1:DW]);
                chk("dbg_rdata", bus.dbg_rdata, e[DW-1:0]);
                obs_idx++;
            end
        end
    end

    // stimulus
    initial begin
        logic [AW-1:0] ra1, ra2, dba, wa;
        logic          we, hwe, lwe;
        int            mode;
        model_clear();

        // reset held across an edge with a write that must be dropped
        step(1, 5, 0, 5, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222);
        step(0, 5, 0, 5, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // zero register
        step(0, 0, 0, 0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 32'h0);
        step(0, 0, 0, 0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // basic write/read
        step(0, 7, 31, 7, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 32'h0);
        step(0, 7, 31, 31, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0);
        step(0, 7, 31, 7, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // async reset pulse between edges clears r7/r31/HI/LO
        step(0, 7, 31, 0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hCAFE_0001, 1'b1, 32'hCAFE_0002);
        step(2, 7, 31, 31, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // same-cycle hazard on r9
        step(0, 9, 9, 9, 1'b1, 5'd9, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(0, 9, 9, 9, 1'b1, 5'd9, 32'h2, 1'b0, 32'h0, 1'b0, 32'h0);
        step(0, 9, 9, 9, 1'b0, 5'd9, 32'h3, 1'b0, 32'h0, 1'b0, 32'h0);
        // HI/LO together with a GPR write
        step(0, 3, 0, 3, 1'b1, 5'd3, 32'h3, 1'b1, 32'h0000_0001, 1'b1, 32'h8000_0000);
        step(0, 3, 3, 3, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            we   = 1'($urandom_range(0, 1));
            wa   = AW'($urandom_range(0, 2**AW - 1));
            ra1  = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, 2**AW - 1));
            ra2  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 2**AW - 1));
            dba  = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, 2**AW - 1));
            hwe  = 1'($urandom_range(0, 1));
            lwe  = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 59) == 0) ? 2 : 0;
            step(mode, ra1, ra2, dba, we, wa, $urandom(), hwe, $urandom(), lwe, $urandom());
        end

        step(0, 0, 0, 0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
